// File: rtl/i2c_bus_conditioner.sv
// I2C pad front end: synchronizes and glitch-filters SCL/SDA, then emits SCL edge,
// START and STOP pulses and tracks bus ownership.
module i2c_bus_conditioner #(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_CYCLES = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_o,
   output logic sda_o,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic bus_busy
);
   localparam int CNT_W  = $clog2(FILT_CYCLES + 1);
   localparam int SETTLE = SYNC_STAGES + FILT_CYCLES + 1;
   localparam int SET_W  = $clog2(SETTLE + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);
   localparam logic [SET_W-1:0] SET_DONE = SET_W'(SETTLE);

   typedef enum logic {IDLE, BUSY} state_t;

   logic [SYNC_STAGES-1:0]  scl_sync_q, sda_sync_q;
   logic [1:0]              synced;
   logic [1:0]              filt_q, filt_d, upd;
   logic [1:0][CNT_W-1:0]   cnt_q, cnt_d;
   logic [SET_W-1:0]        settle_q, settle_d;
   logic                    settled;
   logic                    rise_d, fall_d, start_d, stop_d;
   logic                    rise_q, fall_q, start_q, stop_q;
   logic                    busy_q;
   state_t                  state_q;

   // Index 0 is SCL, index 1 is SDA throughout the filter.
   assign synced = {sda_sync_q[SYNC_STAGES-1], scl_sync_q[SYNC_STAGES-1]};

   always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      upd    = '0;
      for (int i = 0; i < 2; i++) begin
         if (synced[i] != filt_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               filt_d[i] = synced[i];
               upd[i]    = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // START/STOP need a stable SCL high; a same-cycle SCL update masks them.
   assign settled  = (settle_q == SET_DONE);
   assign settle_d = settled ? settle_q : settle_q + 1'b1;
   assign rise_d   = upd[0] && !filt_q[0];
   assign fall_d   = upd[0] &&  filt_q[0];
   assign start_d  = settled && upd[1] &&  filt_q[1] && filt_q[0] && !upd[0];
   assign stop_d   = settled && upd[1] && !filt_q[1] && filt_q[0] && !upd[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         filt_q     <= 2'b11;
         cnt_q      <= '0;
         settle_q   <= '0;
         rise_q     <= 1'b0;
         fall_q     <= 1'b0;
         start_q    <= 1'b0;
         stop_q     <= 1'b0;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
         filt_q     <= filt_d;
         cnt_q      <= cnt_d;
         settle_q   <= settle_d;
         rise_q     <= rise_d;
         fall_q     <= fall_d;
         start_q    <= start_d;
         stop_q     <= stop_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (start_d) begin
               state_q <= BUSY;
               busy_q  <= 1'b1;
            end
            BUSY: if (stop_d) begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign scl_o     = filt_q[0];
   assign sda_o     = filt_q[1];
   assign scl_rise  = rise_q;
   assign scl_fall  = fall_q;
   assign start_det = start_q;
   assign stop_det  = stop_q;
   assign bus_busy  = busy_q;
endmodule
